lsu_wb: RTL and testbench
=========================

// Module: lsu_wb
// PURPOSE
//  Load/store unit between the CPU execute stage and the Wishbone classic master port.
//  Takes one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and runs the bus cycle(s).
//  Handles byte-lane steering and sign/zero extension, and splits misaligned accesses.
//  Handles bus retry and timeout, returning one response per request.
// PARAMETERS
//  RETRY_LIMIT    4    max rty_i re-issues per beat before the request fails with ERR_BUS
//  TIMEOUT_CYCLES 256  cycles stb_o may stay high with no ack_i/err_i/rty_i; 0 disables the watchdog
// PORTS
//  clk_i        in   1   clock; all logic on posedge
//  rst_i        in   1   synchronous, active-high reset
//  req_valid_i  in   1   request present
//  req_ready_o  out  1   high only in IDLE
//  req_we_i     in   1   1=store, 0=load
//  req_funct3_i in   3   FUNCT3_* encoding from params.vh
//  req_addr_i   in   32  byte address (rs1+imm)
//  req_wdata_i  in   32  rs2 value, right-aligned
//  resp_valid_o out  1   one-cycle pulse, one per accepted request
//  resp_rdata_o out  32  extended load data; 0 for stores and on error
//  resp_err_o   out  2   ERR_NONE=0, ERR_ILLEGAL=1, ERR_BUS=2, ERR_TIMEOUT=3
//  cyc_o, stb_o out  1   Wishbone cycle/strobe, always asserted together
//  adr_o        out  32  word address: bits[1:0] always 0
//  sel_o        out  4   byte-lane enables
//  we_o         out  1   write enable
//  dat_o        out  32  lane-steered write data
//  dat_i        in   32  read data
//  ack_i, err_i, rty_i  in 1  cycle termination (priority: err_i > ack_i > rty_i)
// BEHAVIOUR
//  Reset: state IDLE; cyc_o=stb_o=we_o=0; sel_o=0; adr_o=0; dat_o=0; resp_valid_o=0; rdata=0; err=0.
//   Reset mid-cycle drops cyc/stb at the same edge and produces no response.
//  FSM states: IDLE -> BEAT1 -> [BEAT2] -> RESP -> IDLE.
//   Retry pause: RETRY1 returns to BEAT1; RETRY2 returns to BEAT2.
//  IDLE: accept on req_valid_i & req_ready_o; latch all request fields.
//   stb/cyc rise on the next cycle.
//  Illegal funct3 (load 3/6/7, store >=3): no bus cycle; go to RESP with ERR_ILLEGAL.
//  Beat: sel_o = size mask << addr[1:0]; bits beyond lane 3 carry to BEAT2 at adr+4.
//   Straddling accesses (LW off!=0, LH/SH off=3) need BEAT2.
//  Termination, sampled each posedge while stb_o:
//   ack: capture lanes, then advance.
//   err: abort to RESP with ERR_BUS.
//   rty: drop stb/cyc 1 cycle, re-issue the same beat; retry RETRY_LIMIT+1 fails -> ERR_BUS.
//  Watchdog counter clears each beat; hitting TIMEOUT_CYCLES aborts with ERR_TIMEOUT.
//  Error in BEAT2 of a split store leaves BEAT1 bytes written (not rolled back).
//   A split load returns rdata=0 on error.
//  RESP: resp_valid_o=1 for exactly one cycle.
//   Aligned ack at edge N gives resp_valid at N+1; back-to-back requests need 1 idle cycle.
//  LB/LH sign-extend; LBU/LHU zero-extend; width rules are mod 2^32 on adr (wrap at 0xFFFF_FFFC+4 -> 0).
// CONFIGURATION
//  MISALIGNED_SPLIT_EN defined: straddling accesses run as two beats as above.
//  Undefined: any access with addr not size-aligned -> ERR_ILLEGAL with no bus cycle.
//   Without it, BEAT2/RETRY2 are not built.
// STRUCTURE
//  params.vh gains ERR_* codes, LSU state encodings, and SIZE_B/H/W masks.
//  Sub-module lsu_align: combinational lane steer (wdata->dat_o, sel) and merge+extend of read lanes.
// TESTING (flash stub as master target, memory at 0x2000_0000)
//  LB addr 0x2000_0003, mem[0]=0x8302_0100 -> one beat sel=1000, rdata=0xFFFF_FF83, err=0
//  LW addr 0x2000_0002, mem[0]=0xBBBB_AAAA, mem[1]=0xDDDD_CCCC
//   -> beats sel 1100 then 0011, rdata=0xCCCC_BBBB (MISALIGNED_SPLIT_EN)
//   -> without the macro: ERR_ILLEGAL, no stb_o
//  SH 0xF1F0 to 0x2000_0003, mem[0]=mem[1]=0xDEAD_BEEF -> mem[0]=0xF0AD_BEEF, mem[1]=0xDEAD_BEF1
//  Target asserts rty_i 2x then ack_i -> 3 strobes, correct data, err=0
//   rty_i 5x (RETRY_LIMIT=4) -> ERR_BUS
//  No termination, TIMEOUT_CYCLES=8 -> stb_o drops after 8 cycles, ERR_TIMEOUT, rdata=0
//  rst_i pulsed while stb_o high -> cyc/stb low next edge, no resp_valid, req_ready=1

Source files
------------

// File: rtl/lsu_wb_pkg.sv
// Shared types, codes and helpers for the lsu_wb load/store unit.
// The MISALIGNED_SPLIT_EN build option is consumed by lsu_wb.
package lsu_wb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LANES = 4;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  localparam logic [LANES-1:0] SIZE_B = 4'b0001;
  localparam logic [LANES-1:0] SIZE_H = 4'b0011;
  localparam logic [LANES-1:0] SIZE_W = 4'b1111;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_BUS     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BEAT1  = 3'd1,
    ST_RETRY1 = 3'd2,
    ST_BEAT2  = 3'd3,
    ST_RETRY2 = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Request fields held for the whole transaction.
  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [1:0]      off;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  function automatic logic [LANES-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return SIZE_B;
      2'd1:    return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW);
    return (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) || (f3 == FUNCT3_LW) ||
           (f3 == FUNCT3_LBU) || (f3 == FUNCT3_LHU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd1:    return off[0];
      2'd2:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_wb_align.sv
// Byte-lane steering for lsu_wb: store data/sel across two words, and
// merge + sign/zero extension of read lanes.
module lsu_wb_align
  import lsu_wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rlanes,
  output logic [7:0]  sel,
  output logic [63:0] wlanes,
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [5:0]  shamt;
  logic [31:0] rword;

  // Two-word view: lanes 4..7 belong to the following word (second beat).
  always_comb begin
    mask   = size_mask(funct3[1:0]);
    shamt  = {off, 3'b000};
    sel    = {4'b0000, mask} << off;
    wlanes = {32'd0, wdata} << shamt;
    rword  = 32'(rlanes >> shamt);
    case (funct3[1:0])
      2'd0:    rdata = {{24{~funct3[2] & rword[7]}}, rword[7:0]};
      2'd1:    rdata = {{16{~funct3[2] & rword[15]}}, rword[15:0]};
      default: rdata = rword;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// Load/store unit driving a Wishbone classic master port, with retry and watchdog.
// Define MISALIGNED_SPLIT_EN to run word-straddling accesses as two beats.
module lsu_wb
  import lsu_wb_pkg::*;
#(
  parameter int unsigned RETRY_LIMIT    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [1:0]  resp_err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int unsigned RC_W    = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

  state_e          state;
  lsu_req_t        req_q;
  logic [63:0]     rbuf_q;
  err_e            err_q;
  logic [RC_W-1:0] rc_q;
  logic [WD_W-1:0] wd_q;

  logic        idle_c;
  logic [2:0]  al_f3_c;
  logic [1:0]  al_off_c;
  logic [31:0] al_wdata_c;
  logic [7:0]  sel_c;
  logic [63:0] wlanes_c;
  logic [31:0] rdata_c;
  logic        legal_c;
  logic        beat2_c;
  logic        wd_hit_c;
  logic        rc_out_c;

  // Steer from the live request while idle, from the latched one afterwards.
  assign idle_c     = (state == ST_IDLE);
  assign al_f3_c    = idle_c ? req_funct3_i : req_q.funct3;
  assign al_off_c   = idle_c ? req_addr_i[1:0] : req_q.off;
  assign al_wdata_c = idle_c ? req_wdata_i : req_q.wdata;

  lsu_wb_align u_align (
    .funct3 (al_f3_c),
    .off    (al_off_c),
    .wdata  (al_wdata_c),
    .rlanes (rbuf_q),
    .sel    (sel_c),
    .wlanes (wlanes_c),
    .rdata  (rdata_c)
  );

`ifdef MISALIGNED_SPLIT_EN
  logic split_q;
  assign legal_c = funct3_legal(req_we_i, req_funct3_i);
  assign beat2_c = (state == ST_BEAT2);
`else
  logic unused_hi;
  assign legal_c   = funct3_legal(req_we_i, req_funct3_i) &&
                     !misaligned(req_funct3_i, req_addr_i[1:0]);
  assign beat2_c   = 1'b0;
  assign unused_hi = ^{sel_c[7:4], wlanes_c[63:32]};
`endif

  assign wd_hit_c = WD_EN && (wd_q == WD_W'(WD_LAST));
  assign rc_out_c = (rc_q == RC_W'(RETRY_LIMIT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 2'd0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      adr_o        <= '0;
      sel_o        <= '0;
      we_o         <= 1'b0;
      dat_o        <= '0;
      req_q        <= '0;
      rbuf_q       <= '0;
      err_q        <= ERR_NONE;
      rc_q         <= '0;
      wd_q         <= '0;
`ifdef MISALIGNED_SPLIT_EN
      split_q      <= 1'b0;
`endif
    end else begin
      resp_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o  <= 1'b0;
            req_q.we     <= req_we_i;
            req_q.funct3 <= req_funct3_i;
            req_q.off    <= req_addr_i[1:0];
            req_q.wdata  <= req_wdata_i;
            rbuf_q       <= '0;
            rc_q         <= '0;
            wd_q         <= '0;
            if (!legal_c) begin
              err_q <= ERR_ILLEGAL;
              state <= ST_RESP;
            end else begin
              err_q <= ERR_NONE;
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              adr_o <= {req_addr_i[31:2], 2'b00};
              sel_o <= sel_c[3:0];
              we_o  <= req_we_i;
              dat_o <= wlanes_c[31:0];
`ifdef MISALIGNED_SPLIT_EN
              split_q <= |sel_c[7:4];
`endif
              state <= ST_BEAT1;
            end
          end
        end

`ifdef MISALIGNED_SPLIT_EN
        ST_BEAT1, ST_BEAT2: begin
`else
        ST_BEAT1: begin
`endif
          // Termination priority: err > ack > rty, then the watchdog.
          if (err_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            err_q <= ERR_BUS;
            state <= ST_RESP;
          end else if (ack_i) begin
            if (beat2_c) rbuf_q[63:32] <= dat_i;
            else         rbuf_q[31:0]  <= dat_i;
`ifdef MISALIGNED_SPLIT_EN
            if (!beat2_c && split_q) begin
              adr_o <= adr_o + 32'd4;
              sel_o <= sel_c[7:4];
              dat_o <= wlanes_c[63:32];
              rc_q  <= '0;
              wd_q  <= '0;
              state <= ST_BEAT2;
            end else
`endif
            begin
              cyc_o <= 1'b0;
              stb_o <= 1'b0;
              state <= ST_RESP;
            end
          end else if (rty_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            if (rc_out_c) begin
              err_q <= ERR_BUS;
              state <= ST_RESP;
            end else begin
              rc_q  <= rc_q + 1'b1;
              state <= beat2_c ? ST_RETRY2 : ST_RETRY1;
            end
          end else if (wd_hit_c) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            err_q <= ERR_TIMEOUT;
            state <= ST_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

`ifdef MISALIGNED_SPLIT_EN
        ST_RETRY1, ST_RETRY2: begin
`else
        ST_RETRY1: begin
`endif
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          wd_q  <= '0;
          state <= (state == ST_RETRY2) ? ST_BEAT2 : ST_BEAT1;
        end

        ST_RESP: begin
          resp_valid_o <= 1'b1;
          resp_err_o   <= err_q;
          resp_rdata_o <= (req_q.we || (err_q != ERR_NONE)) ? 32'd0 : rdata_c;
          req_ready_o  <= 1'b1;
          state        <= ST_IDLE;
        end

        default: begin
          cyc_o       <= 1'b0;
          stb_o       <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb against a small Wishbone memory target at 0x2000_0000.
// Expectations follow MISALIGNED_SPLIT_EN when it is defined for the build.
module tb_lsu_wb;

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_ILL  = 2'd1;
  localparam logic [1:0] E_BUS  = 2'd2;
  localparam logic [1:0] E_TMO  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'd0;
  logic [31:0] req_addr_i = 32'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic [1:0]  resp_err_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i, rty_i;

  lsu_wb #(.RETRY_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .sel_o(sel_o), .we_o(we_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
  );

  always #5 clk = ~clk;

  // Target configuration, written only by the stimulus process.
  int          rty_cfg = 0;
  logic        err_cfg = 1'b0;
  logic        hang = 1'b0;
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = 3'd0;
  logic [31:0] pl_val = 32'd0;

  // Target model: registered one-shot responses, eight words of memory.
  logic [31:0] mem [8];
  int          rty_used;
  always @(posedge clk) begin
    ack_i <= 1'b0;
    rty_i <= 1'b0;
    err_i <= 1'b0;
    if (pl_en) mem[pl_idx] <= pl_val;
    if (rst_i || resp_valid_o) rty_used <= 0;
    if (rst_i) dat_i <= 32'd0;
    else if (cyc_o && stb_o && !ack_i && !rty_i && !err_i && !hang) begin
      if (rty_used < rty_cfg) begin
        rty_i    <= 1'b1;
        rty_used <= rty_used + 1;
      end else if (err_cfg) begin
        err_i <= 1'b1;
      end else begin
        ack_i <= 1'b1;
        dat_i <= mem[adr_o[4:2]];
        if (we_o)
          for (int i = 0; i < 4; i++)
            if (sel_o[i]) mem[adr_o[4:2]][8*i +: 8] <= dat_o[8*i +: 8];
      end
    end
  end

  // Bus monitor: strobe rises, ack log, strobe run length, response timing.
  int          cyc_cnt = 0, stb_rises = 0, ack_n = 0, resp_n = 0;
  int          run = 0, last_run = 0, last_ack_cyc = 0, last_resp_cyc = 0;
  logic        stb_prev = 1'b0, resp_prev = 1'b0;
  logic [3:0]  sel_log [4];
  logic [31:0] adr_log [4];
  always @(posedge clk) begin
    cyc_cnt   <= cyc_cnt + 1;
    stb_prev  <= stb_o;
    resp_prev <= resp_valid_o;
    if (stb_o && !stb_prev) stb_rises <= stb_rises + 1;
    if (stb_o) run <= run + 1;
    else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
    if (stb_o && ack_i) begin
      sel_log[ack_n % 4] <= sel_o;
      adr_log[ack_n % 4] <= adr_o;
      ack_n        <= ack_n + 1;
      last_ack_cyc <= cyc_cnt;
    end
    if (resp_valid_o) resp_n <= resp_n + 1;
    if (resp_valid_o && !resp_prev) last_resp_cyc <= cyc_cnt;
  end

  int n_checks = 0;
  int n_pass = 0;
  int n_req = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic preload(input logic [2:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request at a negedge and wait (bounded) for its response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] er);
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wd;
    @(negedge clk);
    req_valid_i = 1'b0;
    n_req++;
    n = 0;
    while (!resp_valid_o && n < 100) begin @(negedge clk); n++; end
    if (!resp_valid_o) begin
      check_eq("resp_wait", 32'(resp_valid_o), 32'd1);
      rd = 32'hDEAD_DEAD; er = 2'bxx;
    end else begin
      rd = resp_rdata_o; er = resp_err_o;
    end
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [1:0]  er;
  int          a0, s0, r0;

  initial begin
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("rst_cyc_stb", {30'd0, cyc_o, stb_o}, 32'd0);
    check_eq("rst_adr", adr_o, 32'd0);
    check_eq("rst_sel_we_dat", {27'd0, sel_o, we_o} | dat_o, 32'd0);
    check_eq("rst_resp", {29'd0, resp_valid_o, resp_err_o} | resp_rdata_o, 32'd0);
    check_eq("rst_ready", 32'(req_ready_o), 32'd1);

    // Byte/half loads with sign and zero extension.
    preload(3'd0, 32'h8302_0100);
    a0 = ack_n;
    do_req(1'b0, 3'd0, 32'h2000_0003, 32'd0, rd, er);
    check_eq("lb_rdata", rd, 32'hFFFF_FF83);
    check_eq("lb_err", 32'(er), 32'(E_NONE));
    check_eq("lb_sel", 32'(sel_log[a0 % 4]), 32'b1000);
    check_eq("lb_beats", 32'(ack_n - a0), 32'd1);
    do_req(1'b0, 3'd4, 32'h2000_0003, 32'd0, rd, er);
    check_eq("lbu_rdata", rd, 32'h0000_0083);
    do_req(1'b0, 3'd1, 32'h2000_0002, 32'd0, rd, er);
    check_eq("lh_rdata", rd, 32'hFFFF_8302);
    do_req(1'b0, 3'd5, 32'h2000_0000, 32'd0, rd, er);
    check_eq("lhu_rdata", rd, 32'h0000_0100);

    // Word load straddling two words.
    preload(3'd0, 32'hBBBB_AAAA);
    preload(3'd1, 32'hDDDD_CCCC);
    a0 = ack_n; s0 = stb_rises;
    do_req(1'b0, 3'd2, 32'h2000_0002, 32'd0, rd, er);
`ifdef MISALIGNED_SPLIT_EN
    check_eq("lw_split_rdata", rd, 32'hCCCC_BBBB);
    check_eq("lw_split_err", 32'(er), 32'(E_NONE));
    check_eq("lw_split_beats", 32'(ack_n - a0), 32'd2);
    check_eq("lw_split_sel1", 32'(sel_log[a0 % 4]), 32'b1100);
    check_eq("lw_split_sel2", 32'(sel_log[(a0 + 1) % 4]), 32'b0011);
    check_eq("lw_split_adr2", adr_log[(a0 + 1) % 4], 32'h2000_0004);
`else
    check_eq("lw_mis_err", 32'(er), 32'(E_ILL));
    check_eq("lw_mis_rdata", rd, 32'd0);
    check_eq("lw_mis_nostb", 32'(stb_rises - s0), 32'd0);
`endif

    // Halfword store straddling two words.
    preload(3'd0, 32'hDEAD_BEEF);
    preload(3'd1, 32'hDEAD_BEEF);
    do_req(1'b1, 3'd1, 32'h2000_0003, 32'h0000_F1F0, rd, er);
`ifdef MISALIGNED_SPLIT_EN
    check_eq("sh_split_err", 32'(er), 32'(E_NONE));
    check_eq("sh_split_mem0", mem[0], 32'hF0AD_BEEF);
    check_eq("sh_split_mem1", mem[1], 32'hDEAD_BEF1);
`else
    check_eq("sh_mis_err", 32'(er), 32'(E_ILL));
    check_eq("sh_mis_mem0", mem[0], 32'hDEAD_BEEF);
`endif

    // Address wrap at the top of the space.
    preload(3'd7, 32'h1122_3344);
    preload(3'd0, 32'h5566_7788);
    a0 = ack_n;
    do_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, rd, er);
`ifdef MISALIGNED_SPLIT_EN
    check_eq("wrap_rdata", rd, 32'h7788_1122);
    check_eq("wrap_adr2", adr_log[(a0 + 1) % 4], 32'h0000_0000);
`else
    check_eq("wrap_err", 32'(er), 32'(E_ILL));
`endif

    // Aligned stores, a byte store, read back; also response latency.
    do_req(1'b1, 3'd2, 32'h2000_0008, 32'h1234_5678, rd, er);
    check_eq("sw_rdata_zero", rd, 32'd0);
    do_req(1'b1, 3'd0, 32'h2000_0009, 32'hFFFF_FFAB, rd, er);
    check_eq("sb_mem", mem[2], 32'h1234_AB78);
    do_req(1'b0, 3'd2, 32'h2000_0008, 32'd0, rd, er);
    check_eq("lw_rdata", rd, 32'h1234_AB78);
    check_eq("ack_to_resp", 32'(last_resp_cyc - last_ack_cyc), 32'd2);

    // Illegal funct3: no bus activity.
    s0 = stb_rises;
    do_req(1'b0, 3'd3, 32'h2000_0000, 32'd0, rd, er);
    check_eq("ill_load_err", 32'(er), 32'(E_ILL));
    do_req(1'b1, 3'd4, 32'h2000_0000, 32'd0, rd, er);
    check_eq("ill_store_err", 32'(er), 32'(E_ILL));
    check_eq("ill_nostb", 32'(stb_rises - s0), 32'd0);

    // Retry twice then ack; retry past the limit.
    rty_cfg = 2; s0 = stb_rises;
    do_req(1'b0, 3'd2, 32'h2000_0008, 32'd0, rd, er);
    check_eq("rty2_rdata", rd, 32'h1234_AB78);
    check_eq("rty2_err", 32'(er), 32'(E_NONE));
    check_eq("rty2_strobes", 32'(stb_rises - s0), 32'd3);
    rty_cfg = 5; s0 = stb_rises;
    do_req(1'b0, 3'd2, 32'h2000_0008, 32'd0, rd, er);
    check_eq("rty5_err", 32'(er), 32'(E_BUS));
    check_eq("rty5_rdata", rd, 32'd0);
    check_eq("rty5_strobes", 32'(stb_rises - s0), 32'd5);
    rty_cfg = 0;

    // Bus error.
    err_cfg = 1'b1;
    do_req(1'b0, 3'd2, 32'h2000_0008, 32'd0, rd, er);
    check_eq("buserr_err", 32'(er), 32'(E_BUS));
    check_eq("buserr_rdata", rd, 32'd0);
    err_cfg = 1'b0;

    // No termination: watchdog at 8 cycles.
    hang = 1'b1;
    do_req(1'b0, 3'd2, 32'h2000_0008, 32'd0, rd, er);
    check_eq("tmo_err", 32'(er), 32'(E_TMO));
    check_eq("tmo_rdata", rd, 32'd0);
    check_eq("tmo_stb_cycles", 32'(last_run), 32'd8);

    // Reset while a strobe is outstanding.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'd2; req_addr_i = 32'h2000_0008;
    @(negedge clk);
    req_valid_i = 1'b0;
    check_eq("midrst_stb_before", 32'(stb_o), 32'd1);
    r0 = resp_n;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_cyc_stb", {30'd0, cyc_o, stb_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    hang = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("midrst_noresp", 32'(resp_n - r0), 32'd0);
    check_eq("midrst_ready", 32'(req_ready_o), 32'd1);

    check_eq("resp_count", 32'(resp_n), 32'(n_req));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
